// File: rtl/mips_defs.sv
// Shared MIPS decode constants: opcodes, R-type funct codes, Tuse/Tnew encodings.
// Used by the hazard, forwarding and decode logic.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [4:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_J,
    I_MULT, I_MULTU, I_DIV, I_DIVU, I_MFHI, I_MFLO, I_MTHI, I_MTLO
  } instr_e;

endpackage

// File: rtl/md_busy_cnt.sv
// Busy down-counter of the multi-cycle mult/div unit; an issue always reloads,
// never accumulates.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  output logic             busy,
  output logic [CNT_W-1:0] remain
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Busy includes the issue cycle itself, before the load is visible.
  assign busy   = rst_n & (start | (cnt != '0));
  assign remain = cnt;

endmodule

// File: rtl/hazard_stall.sv
// Stall/bubble generator: Tuse vs Tnew data hazards against the E and M
// producers, plus mult/div occupancy stalls.
module hazard_stall
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ID_Instr_o,
  input  logic [31:0]      EX_Instr_o,
  input  logic [31:0]      MEM_Instr_o,
  input  logic [4:0]       EX_RegAddr_o,
  input  logic [4:0]       MEM_RegAddr_o,
  output logic             stall,
  output logic             ID_EX_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_remain
);

  function automatic instr_e classify(input logic [5:0] op, input logic [5:0] funct);
    instr_e c;
    c = I_NOP;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU:  c = I_ADDU;
          FN_SUBU:  c = I_SUBU;
          FN_JR:    c = I_JR;
          FN_MULT:  c = I_MULT;
          FN_MULTU: c = I_MULTU;
          FN_DIV:   c = I_DIV;
          FN_DIVU:  c = I_DIVU;
          FN_MFHI:  c = I_MFHI;
          FN_MFLO:  c = I_MFLO;
          FN_MTHI:  c = I_MTHI;
          FN_MTLO:  c = I_MTLO;
          default:  c = I_NOP;
        endcase
      end
      OP_ORI:  c = I_ORI;
      OP_LW:   c = I_LW;
      OP_SW:   c = I_SW;
      OP_BEQ:  c = I_BEQ;
      OP_LUI:  c = I_LUI;
      OP_JAL:  c = I_JAL;
      OP_J:    c = I_J;
      default: c = I_NOP;
    endcase
    return c;
  endfunction

  function automatic logic hit(input logic used, input logic [1:0] tuse, input logic [4:0] src,
                               input logic writes, input logic [1:0] tnew, input logic [4:0] dest);
    return used && writes && (dest != 5'd0) && (src == dest) && (tuse < tnew);
  endfunction

  instr_e d_cls, e_cls, m_cls;
  logic [4:0] d_rs, d_rt;
  logic d_rs_used, d_rt_used, d_md;
  logic [1:0] d_rs_tuse, d_rt_tuse;
  logic e_writes, m_writes;
  logic [1:0] e_tnew, m_tnew;
  logic data_stall, md_stall, md_start, md_div;
  logic unused_bits;

  assign d_cls = classify(ID_Instr_o[31:26], ID_Instr_o[5:0]);
  assign e_cls = classify(EX_Instr_o[31:26], EX_Instr_o[5:0]);
  assign m_cls = classify(MEM_Instr_o[31:26], MEM_Instr_o[5:0]);
  assign d_rs  = ID_Instr_o[25:21];
  assign d_rt  = ID_Instr_o[20:16];

  always_comb begin
    d_rs_used = 1'b0;
    d_rt_used = 1'b0;
    d_rs_tuse = TUSE_1;
    d_rt_tuse = TUSE_1;
    d_md      = 1'b0;
    case (d_cls)
      I_BEQ: begin
        d_rs_used = 1'b1; d_rt_used = 1'b1;
        d_rs_tuse = TUSE_0; d_rt_tuse = TUSE_0;
      end
      I_JR: begin
        d_rs_used = 1'b1; d_rs_tuse = TUSE_0;
      end
      I_ADDU, I_SUBU: begin
        d_rs_used = 1'b1; d_rt_used = 1'b1;
      end
      I_ORI, I_LW: d_rs_used = 1'b1;
      I_SW: begin
        d_rs_used = 1'b1; d_rt_used = 1'b1; d_rt_tuse = TUSE_2;
      end
      I_MULT, I_MULTU, I_DIV, I_DIVU: begin
        d_rs_used = 1'b1; d_rt_used = 1'b1; d_md = 1'b1;
      end
      I_MTHI, I_MTLO: begin
        d_rs_used = 1'b1; d_md = 1'b1;
      end
      I_MFHI, I_MFLO: d_md = 1'b1;
      default: ;
    endcase
  end

  // Tnew is counted towards the M/W forwarding points, so a loaded value in M
  // is still one cycle away and everything else in M is already forwardable.
  always_comb begin
    e_writes = 1'b0;
    e_tnew   = TNEW_1;
    m_writes = 1'b0;
    m_tnew   = TNEW_0;
    case (e_cls)
      I_ADDU, I_SUBU, I_ORI, I_LUI, I_MFHI, I_MFLO, I_JAL: e_writes = 1'b1;
      I_LW: begin
        e_writes = 1'b1; e_tnew = TNEW_2;
      end
      default: ;
    endcase
    case (m_cls)
      I_ADDU, I_SUBU, I_ORI, I_LUI, I_MFHI, I_MFLO, I_JAL: m_writes = 1'b1;
      I_LW: begin
        m_writes = 1'b1; m_tnew = TNEW_1;
      end
      default: ;
    endcase
  end

  assign data_stall =
      hit(d_rs_used, d_rs_tuse, d_rs, e_writes, e_tnew, EX_RegAddr_o)  |
      hit(d_rt_used, d_rt_tuse, d_rt, e_writes, e_tnew, EX_RegAddr_o)  |
      hit(d_rs_used, d_rs_tuse, d_rs, m_writes, m_tnew, MEM_RegAddr_o) |
      hit(d_rt_used, d_rt_tuse, d_rt, m_writes, m_tnew, MEM_RegAddr_o);

  assign md_start = (e_cls == I_MULT) || (e_cls == I_MULTU) || (e_cls == I_DIV) || (e_cls == I_DIVU);
  assign md_div   = (e_cls == I_DIV) || (e_cls == I_DIVU);

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_cnt (
    .clk   (clk),
    .rst_n (reset),
    .start (md_start),
    .is_div(md_div),
    .busy  (md_busy),
    .remain(md_remain)
  );

  assign md_stall  = md_busy & d_md;
  assign stall     = reset & (data_stall | md_stall);
  assign ID_EX_clr = stall;

  assign unused_bits = ^{ID_Instr_o[15:6], EX_Instr_o[25:6], MEM_Instr_o[25:6]};

endmodule

// File: tb/tb_hazard_stall.sv
// Randomized and directed checks of hazard_stall against a table-driven model
// that tracks the mult/div unit as an absolute "busy until" cycle.
module tb_hazard_stall;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

  localparam int NOP = 0, ADDU = 1, SUBU = 2, ORI = 3, LW = 4, SW = 5, BEQ = 6, LUI = 7,
                 JAL = 8, JR = 9, J = 10, MULT = 11, MULTU = 12, DIV = 13, DIVU = 14,
                 MFHI = 15, MFLO = 16, MTHI = 17, MTLO = 18, OTHER = 19;

  int tuse_rs [20] = '{-1, 1, 1, 1, 1, 1, 0,-1,-1, 0,-1, 1, 1, 1, 1,-1,-1, 1, 1,-1};
  int tuse_rt [20] = '{-1, 1, 1,-1,-1, 2, 0,-1,-1,-1,-1, 1, 1, 1, 1,-1,-1,-1,-1,-1};
  int tnew_e  [20] = '{-1, 1, 1, 1, 2,-1,-1, 1, 1,-1,-1,-1,-1,-1,-1, 1, 1,-1,-1,-1};
  int tnew_m  [20] = '{-1, 0, 0, 0, 1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1};

  logic clk = 1'b0;
  logic reset;
  logic [31:0] id_instr, ex_instr, mem_instr;
  logic [4:0] ex_dest, mem_dest;
  logic stall, id_ex_clr, md_busy;
  logic [CNT_W-1:0] md_remain;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_until = -100;
  logic obs_stall;

  always #5 clk = ~clk;

  hazard_stall #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_Instr_o   (id_instr),
    .EX_Instr_o   (ex_instr),
    .MEM_Instr_o  (mem_instr),
    .EX_RegAddr_o (ex_dest),
    .MEM_RegAddr_o(mem_dest),
    .stall        (stall),
    .ID_EX_clr    (id_ex_clr),
    .md_busy      (md_busy),
    .md_remain    (md_remain)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int m, input int rs, input int rt, input int rd);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    case (m)
      ADDU:   return {6'h00, s, t, d, 5'h0, 6'h21};
      SUBU:   return {6'h00, s, t, d, 5'h0, 6'h23};
      ORI:    return {6'h0d, s, t, 16'h1234};
      LW:     return {6'h23, s, t, 16'h0010};
      SW:     return {6'h2b, s, t, 16'h0020};
      BEQ:    return {6'h04, s, t, 16'hfffe};
      LUI:    return {6'h0f, 5'h0, t, 16'hbeef};
      JAL:    return {6'h03, 26'h0000100};
      JR:     return {6'h00, s, 15'h0, 6'h08};
      J:      return {6'h02, 26'h0000040};
      MULT:   return {6'h00, s, t, 10'h0, 6'h18};
      MULTU:  return {6'h00, s, t, 10'h0, 6'h19};
      DIV:    return {6'h00, s, t, 10'h0, 6'h1a};
      DIVU:   return {6'h00, s, t, 10'h0, 6'h1b};
      MFHI:   return {6'h00, 10'h0, d, 5'h0, 6'h10};
      MFLO:   return {6'h00, 10'h0, d, 5'h0, 6'h12};
      MTHI:   return {6'h00, s, 15'h0, 6'h11};
      MTLO:   return {6'h00, s, 15'h0, 6'h13};
      OTHER:  return {6'h08, s, t, 16'h0005};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit prod_hit(input int dm, input int drs, input int drt, input int t, input int dest);
    if (t < 0 || dest == 0) return 1'b0;
    if (tuse_rs[dm] >= 0 && drs == dest && tuse_rs[dm] < t) return 1'b1;
    if (tuse_rt[dm] >= 0 && drt == dest && tuse_rt[dm] < t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int md_lat(input int m);
    if (m == MULT || m == MULTU) return MULT_CYCLES;
    if (m == DIV || m == DIVU) return DIV_CYCLES;
    return 0;
  endfunction

  // One pipeline cycle: entered just after a rising edge, leaves just after the next.
  task automatic step(input int dm, input int drs, input int drt,
                      input int em, input int edest, input int mm, input int mdest);
    int rem;
    bit busy_x, stall_x;
    id_instr  = enc(dm, drs, drt, 7);
    ex_instr  = enc(em, 0, 0, edest);
    mem_instr = enc(mm, 0, 0, mdest);
    ex_dest   = edest[4:0];
    mem_dest  = mdest[4:0];
    @(negedge clk);
    rem     = (busy_until - cyc + 1 > 0) ? busy_until - cyc + 1 : 0;
    busy_x  = (md_lat(em) != 0) || (rem > 0);
    stall_x = prod_hit(dm, drs, drt, tnew_e[em], edest) ||
              prod_hit(dm, drs, drt, tnew_m[mm], mdest) ||
              (busy_x && dm >= MULT && dm <= MTLO);
    check("stall", 32'(stall), 32'(stall_x));
    check("id_ex_clr", 32'(id_ex_clr), 32'(stall_x));
    check("md_busy", 32'(md_busy), 32'(busy_x));
    check("md_remain", 32'(md_remain), 32'(rem));
    obs_stall = stall;
    if (md_lat(em) != 0) busy_until = cyc + md_lat(em);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    reset     = 1'b0;
    id_instr  = enc(ADDU, 1, 3, 2);
    ex_instr  = enc(LW, 0, 1, 0);
    mem_instr = 32'h0;
    ex_dest   = 5'd1;
    mem_dest  = 5'd0;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_clr", 32'(id_ex_clr), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_remain", 32'(md_remain), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // load-use and branch hazards
    step(ADDU, 1, 3, LW, 1, NOP, 0);    check("lw_e_addu", 32'(obs_stall), 32'd1);
    step(ADDU, 1, 3, NOP, 0, LW, 1);    check("lw_m_addu", 32'(obs_stall), 32'd0);
    step(BEQ, 4, 0, ADDU, 4, NOP, 0);   check("addu_e_beq", 32'(obs_stall), 32'd1);
    step(BEQ, 4, 0, NOP, 0, ADDU, 4);   check("addu_m_beq", 32'(obs_stall), 32'd0);
    step(BEQ, 4, 0, LW, 4, NOP, 0);     check("lw_e_beq", 32'(obs_stall), 32'd1);
    step(BEQ, 4, 0, NOP, 0, LW, 4);     check("lw_m_beq", 32'(obs_stall), 32'd1);
    step(BEQ, 4, 0, NOP, 0, NOP, 0);    check("lw_w_beq", 32'(obs_stall), 32'd0);
    step(ADDU, 0, 0, LW, 0, NOP, 0);    check("dest_zero", 32'(obs_stall), 32'd0);
    step(SW, 2, 31, JAL, 31, NOP, 0);   check("jal_sw_rt", 32'(obs_stall), 32'd0);

    // mult in E with mflo waiting in D
    step(MFLO, 0, 0, MULT, 0, NOP, 0);
    cnt = obs_stall ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("mult_remain_t1", 32'(md_remain), 32'd5);
      step(MFLO, 0, 0, NOP, 0, NOP, 0);
      if (obs_stall) cnt++;
    end
    check("mult_stall_len", 32'(cnt), 32'd6);

    // div in E with mult waiting; the waiting mult then issues and reloads
    step(MULT, 1, 2, DIV, 0, NOP, 0);
    cnt = obs_stall ? 1 : 0;
    for (int i = 0; i < 14 && obs_stall; i++) begin
      step(MULT, 1, 2, NOP, 0, NOP, 0);
      if (obs_stall) cnt++;
    end
    check("div_stall_len", 32'(cnt), 32'd11);
    step(NOP, 0, 0, MULT, 0, NOP, 0);
    check("mult_reload", 32'(md_remain), 32'd5);
    for (int i = 0; i < 6; i++) step(NOP, 0, 0, NOP, 0, NOP, 0);

    // reset mid-count
    step(NOP, 0, 0, DIV, 0, NOP, 0);
    step(NOP, 0, 0, NOP, 0, NOP, 0);
    step(NOP, 0, 0, NOP, 0, NOP, 0);
    id_instr = enc(MFLO, 0, 0, 3);
    ex_instr = 32'h0;
    #1;
    check("pre_rst_remain", 32'(md_remain), 32'd8);
    check("pre_rst_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(md_busy), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_remain", 32'(md_remain), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    busy_until = -100;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(MFLO, 0, 0, NOP, 0, NOP, 0);

    // random mix: small register numbers so producers and consumers collide often
    for (int i = 0; i < 500; i++) begin
      int ed, md;
      ed = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 3));
      step(int'($urandom_range(0, 19)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 19)), ed, int'($urandom_range(0, 19)), md);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
